// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch queue: 8-entry circular buffer filled up to four words per
// cycle from a combinational imem, drained by issue, with redirect and end-of-memory halt.
module fetch_queue_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd0,
  input  logic [31:0] imem_rd1,
  input  logic [31:0] imem_rd2,
  input  logic [31:0] imem_rd3,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [2:0]  deq_cnt,
  output logic [31:0] instr0,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic [31:0] instr3,
  output logic [3:0]  out_valid,
  output logic [31:0] head_pc,
  output logic [3:0]  q_count,
  output logic        halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;
  localparam state_e      RESET_STATE =
    ({2'b00, RESET_PC_AL[31:2]} >= MEM_WORDS_W) ? HALT : RUN;

  state_e      state_q, state_d;
  logic [31:0] queue_q [8];
  logic [2:0]  head_q, head_d, tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
  logic [2:0]  deq_w, fetch_w;
  logic [3:0]  free_w;
  logic [31:0] fetch_word_w, left_w;
  logic [31:0] redirect_pc_al;
  logic [31:0] rd_w [4];
  logic [31:0] instr_w [4];
  logic        unused_redirect_lsbs;

  assign redirect_pc_al       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign rd_w[0] = imem_rd0;
  assign rd_w[1] = imem_rd1;
  assign rd_w[2] = imem_rd2;
  assign rd_w[3] = imem_rd3;

  // Dequeue and fetch amounts; a redirect cancels both.
  always_comb begin
    deq_w        = 3'd0;
    fetch_w      = 3'd4;
    fetch_word_w = {2'b00, fetch_pc_q[31:2]};
    left_w       = (fetch_word_w >= MEM_WORDS_W) ? 32'd0 : MEM_WORDS_W - fetch_word_w;
    if (deq_cnt <= 3'd4)
      deq_w = ({1'b0, deq_cnt} > count_q) ? count_q[2:0] : deq_cnt;
    free_w = 4'd8 - count_q + {1'b0, deq_w};
    if (free_w < {1'b0, fetch_w}) fetch_w = free_w[2:0];
    if (left_w < {29'd0, fetch_w}) fetch_w = left_w[2:0];
    if (state_q == HALT) fetch_w = 3'd0;
    if (redirect) begin
      deq_w   = 3'd0;
      fetch_w = 3'd0;
    end
  end

  always_comb begin
    head_d     = head_q + deq_w;
    tail_d     = tail_q + fetch_w;
    count_d    = count_q - {1'b0, deq_w} + {1'b0, fetch_w};
    fetch_pc_d = fetch_pc_q + {27'd0, fetch_w, 2'b00};
    head_pc_d  = head_pc_q + {27'd0, deq_w, 2'b00};
    if (redirect) begin
      head_d     = tail_q;
      tail_d     = tail_q;
      count_d    = 4'd0;
      fetch_pc_d = redirect_pc_al;
      head_pc_d  = redirect_pc_al;
    end
  end

  // FSM: state register, next state, output.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = ({2'b00, redirect_pc[31:2]} < MEM_WORDS_W) ? RUN : HALT;
    else if (state_q == RUN && {2'b00, fetch_pc_d[31:2]} >= MEM_WORDS_W)
      state_d = HALT;
  end

  always_comb begin
    halted = (state_q == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= 3'd0;
      tail_q     <= 3'd0;
      count_q    <= 4'd0;
      fetch_pc_q <= RESET_PC_AL;
      head_pc_q  <= RESET_PC_AL;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  // Storage needs no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < fetch_w) queue_q[tail_q + 3'(i)] <= rd_w[i];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_out
    assign instr_w[gi]   = queue_q[head_q + 3'(gi)];
    assign out_valid[gi] = (count_q > 4'(gi));
  end

  assign instr0  = instr_w[0];
  assign instr1  = instr_w[1];
  assign instr2  = instr_w[2];
  assign instr3  = instr_w[3];
  assign imem_a  = fetch_pc_q;
  assign head_pc = head_pc_q;
  assign q_count = count_q;

endmodule

// File: doc/fetch_queue_ctrl.md
FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter MEM_WORDS, default 20, number of valid instruction words in imem; fetch never crosses it.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_a  out  32  fetch address to imem; imem returns words at a, a+4, a+8, a+12 combinationally.
REQ-006 imem_rd0..imem_rd3  in  32 each  imem words at imem_a+0/4/8/12.
REQ-007 redirect  in  1  flush queue and restart fetch at redirect_pc.
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
REQ-009 deq_cnt  in  3  instructions consumed by issue this cycle, 0..4.
REQ-010 instr0..instr3  out  32 each  queue entries head+0..head+3.
REQ-011 out_valid  out  4  bit N set when queue holds more than N entries.
REQ-012 head_pc  out  32  byte address of instr0.
REQ-013 q_count  out  4  occupancy, 0..8.
REQ-014 halted  out  1  fetch stopped at end of memory.

Function
REQ-015 Queue SHALL be 8-entry circular buffer of 32-bit words with 3-bit head and tail pointers wrapping modulo 8.
REQ-016 fetch_pc register SHALL drive imem_a directly (combinational, zero latency).
REQ-017 FSM states RUN and HALT; RUN->HALT when next fetch_pc/4 >= MEM_WORDS; HALT->RUN only on redirect with redirect_pc/4 < MEM_WORDS.
REQ-018 Effective dequeue d = min(deq_cnt, q_count); deq_cnt above q_count SHALL be clamped, never underflow.
REQ-019 Effective dequeue d = 0 when deq_cnt > 4 (values 5..7 treated as 0).
REQ-020 Free space this cycle = 8 - q_count + d.
REQ-021 In RUN, fetch count f = min(4, free space, MEM_WORDS - fetch_pc/4); in HALT, f = 0.
REQ-022 Enqueue imem_rd0..imem_rd(f-1) in order at tail; tail += f; fetch_pc += 4*f.
REQ-023 Dequeue and enqueue SHALL occur in the same cycle; q_count_next = q_count - d + f.
REQ-024 head += d; head_pc += 4*d.
REQ-025 Partial fetch (f < 4) SHALL leave fetch_pc pointing at the first word not enqueued; no word skipped or duplicated.
REQ-026 Redirect has priority over everything: q_count <= 0, head <= tail, fetch_pc <= head_pc <= {redirect_pc[31:2],2'b00}, d and f forced to 0, state per REQ-017.
REQ-027 instrN SHALL show queue[head+N mod 8] regardless of validity; consumers qualify with out_valid[N].
REQ-028 halted = (state == HALT); queue still drains while halted.
REQ-029 Full queue (q_count = 8, d = 0) SHALL give f = 0 and hold fetch_pc.

Reset
REQ-030 On reset: fetch_pc = head_pc = RESET_PC & ~3, head = tail = 0, q_count = 0, out_valid = 4'b0000, state RUN (HALT if RESET_PC/4 >= MEM_WORDS), halted accordingly.
REQ-031 Reset SHALL override redirect and deq_cnt in the same cycle; queue contents need not be cleared.
REQ-032 Reset mid-operation SHALL discard all queued instructions within one cycle.

Verification
REQ-033 Reset, deq_cnt=0 for 3 cycles, imem words = index -> cycle1 q_count=4, imem_a=16; cycle2 q_count=8, imem_a=32; cycle3 q_count=8, imem_a=32 (full, no fetch).
REQ-034 From q_count=8, deq_cnt=3 -> q_count=8 (5 left + 3 fetched), head_pc +12, instr0 = word 3, imem_a=44.
REQ-035 MEM_WORDS=20, run with deq_cnt=4 every cycle -> fetch_pc stops at 80, halted=1 after word 19 enqueued, queue drains to q_count=0, instr order 0..19 with no gaps.
REQ-036 redirect=1, redirect_pc=32'h0000_0013, deq_cnt=4 same cycle with q_count=6 -> next cycle q_count=0, head_pc=imem_a=32'h10, halted=0; following cycle q_count=4, instr0 = word 4.
REQ-037 q_count=2, deq_cnt=4 -> d=2, no underflow; next q_count = f only (4 in RUN).
REQ-038 Assert reset while q_count=5 and halted=1 -> next cycle q_count=0, out_valid=0, halted=0, imem_a=RESET_PC.
